// File: rtl/pin_stream_rx.sv
`default_nettype none
// ============================================================================
//  Module      : pin_stream_rx
//  Description : Receiver for the pin-beacon identification stream. Decodes
//                idle-high, LSB-first 8N1 characters and groups them into
//                records separated by the beacon's inter-word idle gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module pin_stream_rx #(
   parameter int BAUD_DIV  = 867,
   parameter int IDLE_BITS = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rxd,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       frame_err,
   output logic       rec_end,
   output logic [7:0] rec_len,
   output logic       busy
);

   // Bit-timing reload values: full bit, half bit (to centre samples), and
   // full bit minus one for the gap timer, because the stop-sample cycle
   // already counts as the first clock of the idle gap.
   localparam logic [11:0] c_B_M1    = 12'(BAUD_DIV);
   localparam logic [11:0] c_B_M2    = 12'(BAUD_DIV - 1);
   localparam logic [11:0] c_H_M1    = 12'(((BAUD_DIV + 1) / 2) - 1);
   localparam logic [7:0]  c_IDLE_M1 = 8'(IDLE_BITS - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   state_t      r_state, w_state_nxt;
   logic        r_sync0, r_sync1;
   logic        w_rxd_s;
   logic [11:0] r_cnt, w_cnt_nxt;
   logic [2:0]  r_bit, w_bit_nxt;
   logic [7:0]  r_shift, w_shift_nxt;
   logic        r_armed, w_armed_nxt;
   logic        w_fire;
   logic        w_good_stop, w_bad_stop;

   logic [11:0] r_gtim;
   logic [7:0]  r_gap;
   logic        r_open;
   logic        r_rec_end;
   logic [7:0]  r_rec_len;
   logic [7:0]  r_data;
   logic        r_dv, r_fe;

   assign w_rxd_s = r_sync1;
   assign w_fire  = (r_cnt == 12'd0);

   // Two-flop synchronizer on the asynchronous line; presets to idle-high.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync0 <= 1'b1;
         r_sync1 <= 1'b1;
      end else begin
         r_sync0 <= rxd;
         r_sync1 <= r_sync0;
      end
   end

   // Receiver state and bit-timing registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 12'd0;
         r_bit   <= 3'd0;
         r_shift <= 8'd0;
         r_armed <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_bit   <= w_bit_nxt;
         r_shift <= w_shift_nxt;
         r_armed <= w_armed_nxt;
      end
   end

   // Next-state logic: start detect, mid-bit sampling, stop-bit verdict.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = w_fire ? 12'd0 : (r_cnt - 12'd1);
      w_bit_nxt   = r_bit;
      w_shift_nxt = r_shift;
      w_armed_nxt = r_armed;
      w_good_stop = 1'b0;
      w_bad_stop  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_rxd_s) begin
               w_armed_nxt = 1'b1;
            end else if (r_armed) begin
               w_cnt_nxt   = c_H_M1;
               w_state_nxt = S_START;
            end
         end
         S_START: begin
            if (w_fire) begin
               if (!w_rxd_s) begin
                  w_cnt_nxt   = c_B_M1;
                  w_bit_nxt   = 3'd0;
                  w_state_nxt = S_DATA;
               end else begin
                  // Start bit did not survive to mid-bit: treat as a glitch.
                  w_state_nxt = S_IDLE;
               end
            end
         end
         S_DATA: begin
            if (w_fire) begin
               w_shift_nxt = {w_rxd_s, r_shift[7:1]};
               w_cnt_nxt   = c_B_M1;
               if (r_bit == 3'd7) begin
                  w_state_nxt = S_STOP;
               end else begin
                  w_bit_nxt = r_bit + 3'd1;
               end
            end
         end
         S_STOP: begin
            if (w_fire) begin
               w_state_nxt = S_IDLE;
               if (w_rxd_s) begin
                  w_good_stop = 1'b1;
               end else begin
                  // Low stop bit may be a break; wait for the line to go
                  // high before accepting another start edge.
                  w_bad_stop  = 1'b1;
                  w_armed_nxt = 1'b0;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Byte output and one-cycle character pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_data <= 8'd0;
         r_dv   <= 1'b0;
         r_fe   <= 1'b0;
      end else begin
         r_dv <= w_good_stop;
         r_fe <= w_bad_stop;
         if (w_good_stop) begin
            r_data <= r_shift;
         end
      end
   end

   // Record gap timer: counts idle bit periods while a record is open.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_gtim    <= 12'd0;
         r_gap     <= 8'd0;
         r_open    <= 1'b0;
         r_rec_end <= 1'b0;
      end else begin
         r_rec_end <= 1'b0;
         if (w_good_stop) begin
            r_gtim <= c_B_M2;
            r_gap  <= 8'd0;
            r_open <= 1'b1;
         end else if (!w_rxd_s) begin
            r_gtim <= c_B_M1;
            r_gap  <= 8'd0;
         end else if ((r_state == S_IDLE) && r_open) begin
            if (r_gtim == 12'd0) begin
               r_gtim <= c_B_M1;
               if (r_gap == c_IDLE_M1) begin
                  r_rec_end <= 1'b1;
                  r_open    <= 1'b0;
                  r_gap     <= 8'd0;
               end else begin
                  r_gap <= r_gap + 8'd1;
               end
            end else begin
               r_gtim <= r_gtim - 12'd1;
            end
         end
      end
   end

   // Record length: saturating byte count, cleared the cycle after rec_end.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rec_len <= 8'd0;
      end else if (r_rec_end) begin
         r_rec_len <= 8'd0;
      end else if (w_good_stop && (r_rec_len != 8'hFF)) begin
         r_rec_len <= r_rec_len + 8'd1;
      end
   end

   assign data_out   = r_data;
   assign data_valid = r_dv;
   assign frame_err  = r_fe;
   assign rec_end    = r_rec_end;
   assign rec_len    = r_rec_len;
   assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pin_stream_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pin_stream_rx
//  Description : Directed self-checking bench for pin_stream_rx
//                (BAUD_DIV=15 -> 16 clocks/bit, IDLE_BITS=10).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pin_stream_rx;

   localparam int c_B = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rxd = 1'b1;
   logic [7:0] data_out;
   logic       data_valid;
   logic       frame_err;
   logic       rec_end;
   logic [7:0] rec_len;
   logic       busy;

   int n_vec = 0;
   int n_bad = 0;
   int cyc   = 0;

   int         q_dv_cyc[$];
   logic [7:0] q_dv_dat[$];
   int         q_fe_cyc[$];
   int         q_re_cyc[$];
   int         q_re_len[$];
   int         q_re_after[$];
   logic       last_re = 1'b0;

   pin_stream_rx #(.BAUD_DIV(15), .IDLE_BITS(10)) dut (
      .clk        (clk),
      .rst        (rst),
      .rxd        (rxd),
      .data_out   (data_out),
      .data_valid (data_valid),
      .frame_err  (frame_err),
      .rec_end    (rec_end),
      .rec_len    (rec_len),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Event log, sampled on the falling edge.
   always @(negedge clk) begin
      if (last_re) q_re_after.push_back(int'(rec_len));
      last_re = (rec_end === 1'b1);
      if (data_valid === 1'b1) begin
         q_dv_cyc.push_back(cyc);
         q_dv_dat.push_back(data_out);
      end
      if (frame_err === 1'b1) q_fe_cyc.push_back(cyc);
      if (rec_end === 1'b1) begin
         q_re_cyc.push_back(cyc);
         q_re_len.push_back(int'(rec_len));
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic flush();
      q_dv_cyc.delete();
      q_dv_dat.delete();
      q_fe_cyc.delete();
      q_re_cyc.delete();
      q_re_len.delete();
      q_re_after.delete();
   endtask

   task automatic drive_bit(input logic b);
      rxd = b;
      repeat (c_B) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      drive_bit(stop);
   endtask

   task automatic idle(input int n);
      rxd = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int t;
      int t2;
      int bcnt;
      int bfirst;
      int blast;

      // ---- Reset state ----
      rst = 1'b1;
      rxd = 1'b1;
      repeat (4) @(negedge clk);
      chk("rst_data_out",   data_out,   32'h0);
      chk("rst_data_valid", data_valid, 32'h0);
      chk("rst_frame_err",  frame_err,  32'h0);
      chk("rst_rec_end",    rec_end,    32'h0);
      chk("rst_rec_len",    rec_len,    32'h0);
      chk("rst_busy",       busy,       32'h0);
      rst = 1'b0;
      idle(10);
      flush();

      // ---- Byte decode 0xA5: data_valid at T0+153, T0 = line edge + 2 ----
      t = cyc;
      send_frame(8'hA5, 1'b1);
      idle(20);
      chk("a5_dv_count", q_dv_cyc.size(), 32'd1);
      if (q_dv_cyc.size() >= 1) begin
         chk("a5_dv_cycle", q_dv_cyc[0] - t, 32'd155);
         chk("a5_data",     q_dv_dat[0],     32'hA5);
      end
      chk("a5_fe_count", q_fe_cyc.size(), 32'd0);
      chk("a5_rec_len",  rec_len,         32'd1);
      idle(200);
      flush();

      // ---- Glitch: 3 clocks low; busy only in cycles T0+1..T0+8 ----
      t = cyc;
      bcnt = 0; bfirst = -1; blast = -1;
      rxd = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (i == 3) rxd = 1'b1;
         if (busy === 1'b1) begin
            bcnt++;
            if (bfirst < 0) bfirst = i;
            blast = i;
         end
         @(negedge clk);
      end
      idle(20);
      chk("glitch_busy_cycles", bcnt,   32'd8);
      chk("glitch_busy_first",  bfirst, 32'd3);
      chk("glitch_busy_last",   blast,  32'd10);
      chk("glitch_dv_count",    q_dv_cyc.size(), 32'd0);
      chk("glitch_fe_count",    q_fe_cyc.size(), 32'd0);
      flush();

      // ---- Framing error, break hold, then 0x81 ----
      t = cyc;
      send_frame(8'h3C, 1'b0);
      rxd = 1'b0;
      repeat (100) @(negedge clk);
      idle(20);
      t2 = cyc;
      send_frame(8'h81, 1'b1);
      idle(20);
      chk("brk_fe_count", q_fe_cyc.size(), 32'd1);
      if (q_fe_cyc.size() >= 1) chk("brk_fe_cycle", q_fe_cyc[0] - t, 32'd155);
      chk("brk_dv_count", q_dv_cyc.size(), 32'd1);
      if (q_dv_cyc.size() >= 1) begin
         chk("brk_dv_cycle", q_dv_cyc[0] - t2, 32'd155);
         chk("brk_data",     q_dv_dat[0],      32'h81);
      end
      chk("brk_rec_len", rec_len, 32'd1);
      idle(200);
      flush();

      // ---- Back-to-back 0x00, 0xFF ----
      t = cyc;
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      idle(20);
      chk("b2b_dv_count", q_dv_cyc.size(), 32'd2);
      if (q_dv_cyc.size() >= 2) begin
         chk("b2b_first_cycle", q_dv_cyc[0] - t,           32'd155);
         chk("b2b_spacing",     q_dv_cyc[1] - q_dv_cyc[0], 32'd160);
         chk("b2b_data0",       q_dv_dat[0],               32'h00);
         chk("b2b_data1",       q_dv_dat[1],               32'hFF);
      end
      chk("b2b_rec_len", rec_len, 32'd2);
      idle(200);
      flush();

      // ---- Record close after 4 bytes: last stop sample at t+634 ----
      t = cyc;
      send_frame(8'h11, 1'b1);
      send_frame(8'h22, 1'b1);
      send_frame(8'h33, 1'b1);
      send_frame(8'h44, 1'b1);
      idle(600);
      chk("rec_dv_count", q_dv_cyc.size(), 32'd4);
      chk("rec_end_count", q_re_cyc.size(), 32'd1);
      if (q_re_cyc.size() >= 1) begin
         chk("rec_end_cycle",   q_re_cyc[0] - t, 32'd794);
         chk("rec_len_at_end",  q_re_len[0],     32'd4);
      end
      if (q_re_after.size() >= 1) chk("rec_len_after_end", q_re_after[0], 32'd0);
      else chk("rec_len_after_logged", q_re_after.size(), 32'd1);
      chk("rec_len_idle", rec_len, 32'd0);
      flush();

      // ---- Reset during DATA bit 4 of 0x55, then 0x96 ----
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(i[0] ? 1'b0 : 1'b1);
      rxd = 1'b1;
      repeat (4) @(negedge clk);
      chk("mid_busy_before", busy, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_data_out", data_out, 32'h0);
      chk("mid_rst_busy",     busy,     32'h0);
      chk("mid_rst_rec_len",  rec_len,  32'h0);
      rst = 1'b0;
      idle(200);
      chk("mid_no_dv", q_dv_cyc.size(), 32'd0);
      chk("mid_no_fe", q_fe_cyc.size(), 32'd0);
      chk("mid_no_re", q_re_cyc.size(), 32'd0);
      flush();
      t = cyc;
      send_frame(8'h96, 1'b1);
      idle(20);
      chk("post_dv_count", q_dv_cyc.size(), 32'd1);
      if (q_dv_cyc.size() >= 1) begin
         chk("post_dv_cycle", q_dv_cyc[0] - t, 32'd155);
         chk("post_data",     q_dv_dat[0],     32'h96);
      end
      chk("post_rec_len", rec_len, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pin_stream_rx.md
Name: pin_stream_rx

Overview:
- Serial receiver for the pin-identification stream that the FPGA-side pin beacon drives onto each package pin.
- Sits on the bench/probe fixture, one instance per probed line.
- Decodes idle-high, LSB-first, 8N1 async characters at the beacon's baud divider.
- Groups characters into records, using the beacon's inter-word idle gap as the record boundary.
- Reports each byte, framing errors, record end and record length.

Parameters:
- BAUD_DIV, 867: clock cycles per bit minus one; same meaning as the beacon's divider. B = BAUD_DIV+1 clocks per bit; H = B/2 (integer division). Legal range 3..4095.
- IDLE_BITS, 10: count of consecutive idle bit-periods after a good stop bit that closes a record. Legal range 1..255.

Ports:
- clk, input, 1: single clock; all logic on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- rxd, input, 1: asynchronous serial line, idle high.
- data_out, output, 8: last received byte.
- data_valid, output, 1: one-cycle pulse; data_out is valid in that cycle.
- frame_err, output, 1: one-cycle pulse when the stop bit samples low.
- rec_end, output, 1: one-cycle pulse when a record closes.
- rec_len, output, 8: bytes in the current record; saturates at 255.
- busy, output, 1: high in any state other than IDLE.

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE.
  - data_out=0, data_valid=0, frame_err=0, rec_end=0, rec_len=0, busy=0.
  - Synchronizer flops preset to 1; armed=1; gap counter=0; rec_open=0.
  - A reset mid-character discards the partial byte with no pulses.
- Input path: 2-flop synchronizer gives rxd_s. Only rxd_s is used internally.
- Bit counter: loaded with N, decrements each clock, fires when it reaches 0, i.e. N+1 clocks after loading.
- IDLE:
  - If armed and rxd_s=0: load counter with H-1, go to START. T0 is this cycle.
  - If rxd_s=1: set armed.
- START, on counter fire at T0+H:
  - rxd_s=0: load B-1, bit index=0, go to DATA.
  - rxd_s=1: glitch; go to IDLE with no pulse, armed stays 1.
- DATA:
  - Bit k (k=0..7) is sampled at T0+H+(k+1)*B and shifted in LSB-first; counter reloads B-1.
  - After bit 7, go to STOP.
- STOP, sampled at T0+H+9B:
  - rxd_s=1 (good stop):
    - In cycle T0+H+9B+1: data_out=byte, data_valid=1.
    - rec_len increments (saturating at 255); rec_open=1; gap counter clears.
    - Go to IDLE.
  - rxd_s=0 (bad stop):
    - In cycle T0+H+9B+1: frame_err=1.
    - data_out unchanged, rec_len unchanged.
    - armed=0 (break protection: no new start until rxd_s has been seen high). Go to IDLE.
- Back-to-back characters: a start edge may be detected in the cycle after the stop sample; no idle bit is required.
- Record gap:
  - While IDLE, rec_open=1 and rxd_s=1, a free bit timer counts B-clock periods.
  - Any rxd_s=0 clears the gap counter.
  - When IDLE_BITS full periods elapse: rec_end=1 for one cycle, rec_open=0.
  - rec_len holds its value during the rec_end cycle and reads 0 from the next cycle.
  - rec_end never fires without at least one good byte since the last rec_end or reset.
  - A frame_err does not open or close a record.
- Simultaneous events: data_valid, frame_err and rec_end are mutually exclusive by construction.
- Widths: the bit counter is 12 bits; no wrap occurs within the legal BAUD_DIV range.

Test Plan:
- Byte decode: BAUD_DIV=15 (B=16, H=8). Send 0xA5 (start, 1,0,1,0,0,1,0,1, stop) -> data_valid for exactly 1 cycle at T0+153 with data_out=0xA5; rec_len=1; no frame_err.
- Glitch rejection: rxd low for 3 clocks, then high -> state returns to IDLE at T0+8; no data_valid or frame_err; busy high only between T0 and T0+8.
- Framing error and break: 0x3C with stop bit low, then rxd held low 100 clocks, then high and 0x81 sent -> one frame_err, no data_valid for 0x3C, no spurious start during the low hold, then data_valid with 0x81.
- Back-to-back: 0x00 then 0xFF with zero idle between -> two data_valid pulses exactly 10*B=160 cycles apart, values 0x00 and 0xFF, rec_len=2.
- Record close: IDLE_BITS=10; after 4 bytes, hold rxd high -> single rec_end 10*16=160 cycles after the last stop sample, rec_len=4 in that cycle and 0 after; no further rec_end while the line stays idle.
- Reset mid-byte: assert rst during DATA bit 4 of 0x55 -> all outputs 0 the next cycle, no pulses; the following 0x96 decodes correctly with rec_len=1.
